// File: rtl/reg_shadow_stack.sv
// Working register b with a LIFO shadow stack driven by sequencer cs codes.
// Define REG_SHADOW_STACK_ERR_EN to enable the sticky ovf/unf flags.
module reg_shadow_stack #(
  parameter int         WIDTH     = 4,
  parameter int         DEPTH     = 4,
  parameter logic [4:0] LOAD_CODE = 5'b10010,
  parameter logic [4:0] PUSH_CODE = 5'b11100,
  parameter logic [4:0] POP_CODE  = 5'b11101,
  parameter logic [4:0] CLR_CODE  = 5'b11110
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4:0]                 cs,
  input  logic [WIDTH-1:0]           datoin,
  output logic [WIDTH-1:0]           b,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] b_reg, b_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic             is_load, is_push, is_pop;
  logic             push_ok, pop_ok;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign is_load = (cs == LOAD_CODE);
  assign is_push = (cs == PUSH_CODE);
  assign is_pop  = (cs == POP_CODE);

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = is_push && !full;
  assign pop_ok  = is_pop && !empty;

  // Index arithmetic wraps modulo 2**AW, so count == DEPTH still yields top = DEPTH-1.
  assign wr_idx = count_reg[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);

  always_comb begin
    b_next     = b_reg;
    count_next = count_reg;
    if (is_load) begin
      b_next = datoin;
    end else if (push_ok) begin
      count_next = count_reg + CW'(1);
    end else if (pop_ok) begin
      b_next     = stack_mem[rd_idx];
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_reg     <= '0;
      count_reg <= '0;
    end else begin
      b_reg     <= b_next;
      count_reg <= count_next;
    end
  end

  // Storage is deliberately unreset; validity is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (push_ok && !is_load) begin
      stack_mem[wr_idx] <= b_reg;
    end
  end

`ifdef REG_SHADOW_STACK_ERR_EN
  logic is_clr;
  logic ovf_reg, unf_reg;

  assign is_clr = (cs == CLR_CODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else if (is_clr) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (is_push && full)  ovf_reg <= 1'b1;
      if (is_pop  && empty) unf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
  assign unf = unf_reg;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

  assign b     = b_reg;
  assign count = count_reg;

endmodule
